wishbone_dm_regfile: RTL and testbench

WISHBONE_DM_REGFILE -- requirements
Module: wishbone_dm_regfile

---
 rtl/dm_pkg.sv | 78 +++++++
 rtl/dm_data_bank.sv | 52 +++++
 rtl/wishbone_dm_regfile.sv | 252 +++++++++++++++++++++++++
 tb/tb_wishbone_dm_regfile.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the debug-module register file:
//   - register word addresses (data0, dmcontrol, dmstatus, abstractcs, progbuf0)
//   - dmcontrol / dmstatus / abstractcs bit positions and the version value
//   - Wishbone slave FSM state encoding
//   - helper functions that assemble the read-only status words
// ---------------------------------------------------------------------------
package dm_pkg;

    // Register word addresses (addr_i[6:0]; addr_i[31:7] must be zero)
    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_PROGBUF0   = 7'h20;

    // dmcontrol bit positions
    localparam int DMCONTROL_DMACTIVE  = 0;
    localparam int DMCONTROL_NDMRESET  = 1;
    localparam int DMCONTROL_RESUMEREQ = 30;
    localparam int DMCONTROL_HALTREQ   = 31;

    // dmstatus bit positions
    localparam int DMSTATUS_VERSION_LSB   = 0;
    localparam int DMSTATUS_AUTHENTICATED = 7;
    localparam int DMSTATUS_ANYHALTED     = 8;
    localparam int DMSTATUS_ALLHALTED     = 9;
    localparam int DMSTATUS_ANYRUNNING    = 10;
    localparam int DMSTATUS_ALLRUNNING    = 11;

    // abstractcs field positions
    localparam int ABSTRACTCS_DATACOUNT_LSB   = 0;
    localparam int ABSTRACTCS_PROGBUFSIZE_LSB = 24;

    localparam logic [3:0] DM_VERSION = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_ERR  = 2'd2
    } dm_state_e;

    function automatic logic [31:0] dmcontrol_word(input logic haltreq,
                                                   input logic ndmreset,
                                                   input logic dmactive);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[DMCONTROL_HALTREQ]  = haltreq;
        v[DMCONTROL_NDMRESET] = ndmreset;
        v[DMCONTROL_DMACTIVE] = dmactive;
        return v;
    endfunction

    // Single hart: "any" and "all" flags are the same status bit.
    function automatic logic [31:0] dmstatus_word(input logic halted,
                                                  input logic running);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[DMSTATUS_ALLRUNNING]    = running;
        v[DMSTATUS_ANYRUNNING]    = running;
        v[DMSTATUS_ALLHALTED]     = halted;
        v[DMSTATUS_ANYHALTED]     = halted;
        v[DMSTATUS_AUTHENTICATED] = 1'b1;
        v[DMSTATUS_VERSION_LSB +: 4] = DM_VERSION;
        return v;
    endfunction

    function automatic logic [31:0] abstractcs_word(input logic [4:0] pbsize,
                                                    input logic [3:0] dcount);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[ABSTRACTCS_PROGBUFSIZE_LSB +: 5] = pbsize;
        v[ABSTRACTCS_DATACOUNT_LSB +: 4]   = dcount;
        return v;
    endfunction

endpackage

// File: rtl/dm_data_bank.sv
// ---------------------------------------------------------------------------
// dm_data_bank
// Bank of N 32-bit registers with one write port and one read port sharing
// the same index. Synchronous reset and synchronous clear both zero the bank.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_clr    synchronous clear of every entry
//   i_we     write enable for entry i_idx
//   i_idx    entry index (out-of-range index reads 0 and writes nothing)
//   i_wdata  write data
//   o_rdata  combinational read data of entry i_idx
// ---------------------------------------------------------------------------
module dm_data_bank #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [N];

    // Storage: reset/clear dominate, otherwise write the addressed entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (i_we) begin
            for (int i = 0; i < N; i++) begin
                if (i_idx == IDX_W'(i)) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Read mux: OR of the single matching entry, so an unused index reads 0.
    always_comb begin
        o_rdata = 32'h0000_0000;
        for (int i = 0; i < N; i++) begin
            o_rdata = o_rdata | ((i_idx == IDX_W'(i)) ? r_mem[i] : 32'h0000_0000);
        end
    end

endmodule

// File: rtl/wishbone_dm_regfile.sv
// ---------------------------------------------------------------------------
// wishbone_dm_regfile
// Wishbone slave exposing a minimal debug-module register file:
//   data0..data(DATA_COUNT-1) @0x04, dmcontrol @0x10, dmstatus @0x11,
//   abstractcs @0x16, progbuf0.. @0x20 (only with WISHBONE_DM_PROGBUF_EN).
// Every transaction terminates one cycle after the strobe with ack_o (mapped)
// or err_o (unmapped); the bus must drop cyc_i and stb_i before the next one.
// Configuration macro:
//   WISHBONE_DM_PROGBUF_EN  defined   -> progbuf bank present, progbufsize = PROGBUF_SIZE
//                           undefined -> 0x20.. unmapped, progbufsize = 0
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   addr_i, we_i, data_i         word address, write strobe, write data
//   cyc_i, stb_i                 Wishbone cycle / strobe
//   data_o, ack_o, err_o         read data, normal / error termination
//   hart_halted_i/running_i      hart status reported in dmstatus
//   dmactive_o, ndmreset_o,
//   haltreq_o                    dmcontrol levels
//   resumereq_o                  one-cycle pulse after a resumereq write
// ---------------------------------------------------------------------------
module wishbone_dm_regfile
    import dm_pkg::*;
#(
    parameter int DATA_COUNT   = 2,
    parameter int PROGBUF_SIZE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        err_o,
    input  logic        hart_halted_i,
    input  logic        hart_running_i,
    output logic        dmactive_o,
    output logic        ndmreset_o,
    output logic        haltreq_o,
    output logic        resumereq_o
);

    localparam int         DIDX_W     = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam logic [6:0] L_DATA_END = ADDR_DATA0 + 7'(DATA_COUNT);

    if (DATA_COUNT < 1 || DATA_COUNT > 12) begin : g_bad_data_count
        $error("DATA_COUNT must be in 1..12");
    end
    if (PROGBUF_SIZE < 1 || PROGBUF_SIZE > 16) begin : g_bad_progbuf_size
        $error("PROGBUF_SIZE must be in 1..16");
    end

    dm_state_e   r_state;
    dm_state_e   w_state_nxt;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_data;
    logic        r_dmactive;
    logic        r_ndmreset;
    logic        r_haltreq;
    logic        r_resumereq;

    logic [6:0]        w_word;
    logic              w_hi_zero;
    logic              w_is_data;
    logic              w_is_pb;
    logic              w_is_dmcontrol;
    logic              w_is_dmstatus;
    logic              w_is_abstractcs;
    logic              w_mapped;
    logic              w_req;
    logic              w_commit;
    logic              w_wr;
    logic              w_ctl_wr;
    logic              w_ctl_update;
    logic              w_deactivate;
    logic              w_data_we;
    logic [DIDX_W-1:0] w_data_idx;
    logic [31:0]       w_data_rdata;
    logic [31:0]       w_pb_rdata;
    logic [31:0]       w_rdata;
    logic [4:0]        w_pbsize;

    // ---------------- address decode ----------------
    assign w_word          = addr_i[6:0];
    assign w_hi_zero       = (addr_i[31:7] == 25'd0);
    assign w_is_data       = w_hi_zero && (w_word >= ADDR_DATA0) && (w_word < L_DATA_END);
    assign w_is_dmcontrol  = w_hi_zero && (w_word == ADDR_DMCONTROL);
    assign w_is_dmstatus   = w_hi_zero && (w_word == ADDR_DMSTATUS);
    assign w_is_abstractcs = w_hi_zero && (w_word == ADDR_ABSTRACTCS);
    assign w_mapped        = w_is_data | w_is_pb | w_is_dmcontrol | w_is_dmstatus | w_is_abstractcs;
    assign w_data_idx      = DIDX_W'(w_word - ADDR_DATA0);

    // ---------------- commit qualifiers ----------------
    // A transaction is committed only on the IDLE->ACK edge; held ACK cycles
    // never reach this term, so they cannot rewrite anything.
    assign w_req        = cyc_i & stb_i;
    assign w_commit     = (r_state == ST_IDLE) & w_req & w_mapped;
    assign w_wr         = w_commit & we_i;
    assign w_ctl_wr     = w_wr & w_is_dmcontrol;
    // While inactive, a dmcontrol write only touches dmactive.
    assign w_ctl_update = w_ctl_wr & r_dmactive & data_i[DMCONTROL_DMACTIVE];
    assign w_deactivate = w_ctl_wr & r_dmactive & ~data_i[DMCONTROL_DMACTIVE];
    // Data/progbuf stay at zero while the module is inactive.
    assign w_data_we    = w_wr & w_is_data & r_dmactive;

    dm_data_bank #(
        .N     (DATA_COUNT),
        .IDX_W (DIDX_W)
    ) u_data_bank (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clr   (w_deactivate),
        .i_we    (w_data_we),
        .i_idx   (w_data_idx),
        .i_wdata (data_i),
        .o_rdata (w_data_rdata)
    );

`ifdef WISHBONE_DM_PROGBUF_EN
    localparam int         PIDX_W   = (PROGBUF_SIZE > 1) ? $clog2(PROGBUF_SIZE) : 1;
    localparam logic [6:0] L_PB_END = ADDR_PROGBUF0 + 7'(PROGBUF_SIZE);

    logic [PIDX_W-1:0] w_pb_idx;
    logic              w_pb_we;

    assign w_is_pb  = w_hi_zero && (w_word >= ADDR_PROGBUF0) && (w_word < L_PB_END);
    assign w_pb_idx = PIDX_W'(w_word - ADDR_PROGBUF0);
    assign w_pb_we  = w_wr & w_is_pb & r_dmactive;
    assign w_pbsize = 5'(PROGBUF_SIZE);

    dm_data_bank #(
        .N     (PROGBUF_SIZE),
        .IDX_W (PIDX_W)
    ) u_progbuf_bank (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clr   (w_deactivate),
        .i_we    (w_pb_we),
        .i_idx   (w_pb_idx),
        .i_wdata (data_i),
        .o_rdata (w_pb_rdata)
    );
`else
    assign w_is_pb    = 1'b0;
    assign w_pb_rdata = 32'h0000_0000;
    assign w_pbsize   = 5'd0;
`endif

    // Read mux for the addressed register (captured only at read commit).
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_is_data) begin
            w_rdata = w_data_rdata;
        end else if (w_is_pb) begin
            w_rdata = w_pb_rdata;
        end else if (w_is_dmcontrol) begin
            w_rdata = dmcontrol_word(r_haltreq, r_ndmreset, r_dmactive);
        end else if (w_is_dmstatus) begin
            w_rdata = dmstatus_word(hart_halted_i, hart_running_i);
        end else if (w_is_abstractcs) begin
            w_rdata = abstractcs_word(w_pbsize, 4'(DATA_COUNT));
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // FSM next state: accept only from IDLE, release when cyc and stb drop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_mapped ? ST_ACK : ST_ERR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK, ST_ERR: begin
                if (!cyc_i && !stb_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered bus outputs: terminations follow the next state, read data
    // is captured at commit and held only while the FSM stays in ACK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= 32'h0000_0000;
        end else begin
            r_ack <= (w_state_nxt == ST_ACK);
            r_err <= (w_state_nxt == ST_ERR);
            if (w_commit && !we_i) begin
                r_data <= w_rdata;
            end else if (w_state_nxt == ST_ACK) begin
                r_data <= r_data;
            end else begin
                r_data <= 32'h0000_0000;
            end
        end
    end

    // dmcontrol state and the one-cycle resumereq pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dmactive  <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_haltreq   <= 1'b0;
            r_resumereq <= 1'b0;
        end else if (w_ctl_wr) begin
            r_dmactive <= data_i[DMCONTROL_DMACTIVE];
            if (w_ctl_update) begin
                r_haltreq   <= data_i[DMCONTROL_HALTREQ];
                r_ndmreset  <= data_i[DMCONTROL_NDMRESET];
                r_resumereq <= data_i[DMCONTROL_RESUMEREQ];
            end else begin
                r_haltreq   <= 1'b0;
                r_ndmreset  <= 1'b0;
                r_resumereq <= 1'b0;
            end
        end else begin
            r_resumereq <= 1'b0;
        end
    end

    assign ack_o       = r_ack;
    assign err_o       = r_err;
    assign data_o      = r_data;
    assign dmactive_o  = r_dmactive;
    assign ndmreset_o  = r_ndmreset;
    assign haltreq_o   = r_haltreq;
    assign resumereq_o = r_resumereq;

endmodule

// File: tb/tb_wishbone_dm_regfile.sv
// ---------------------------------------------------------------------------
// tb_wishbone_dm_regfile
// Self-checking bench for wishbone_dm_regfile (default parameters): a table
// of directed transactions, hand-written multi-cycle sequences (resumereq
// pulse, held ACK, reset mid-transaction) and a randomized phase compared
// against a behavioural model of the register map.
// ---------------------------------------------------------------------------
module tb_wishbone_dm_regfile;

    localparam int DC = 2;
    localparam int PB = 4;
`ifdef WISHBONE_DM_PROGBUF_EN
    localparam bit PB_EN = 1'b1;
`else
    localparam bit PB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        halted;
    logic        running;
    logic        dmactive;
    logic        ndmreset;
    logic        haltreq;
    logic        resumereq;

    always #5 clk = ~clk;

    wishbone_dm_regfile #(
        .DATA_COUNT   (DC),
        .PROGBUF_SIZE (PB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .addr_i         (addr),
        .we_i           (we),
        .data_i         (wdata),
        .data_o         (rdata),
        .cyc_i          (cyc),
        .stb_i          (stb),
        .ack_o          (ack),
        .err_o          (err),
        .hart_halted_i  (halted),
        .hart_running_i (running),
        .dmactive_o     (dmactive),
        .ndmreset_o     (ndmreset),
        .haltreq_o      (haltreq),
        .resumereq_o    (resumereq)
    );

    int    n_vec = 0;
    int    n_err = 0;
    string cur_tag = "init";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur_tag, nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_data [DC];
    logic [31:0] m_pb   [PB];
    logic        m_active, m_halt, m_ndm;

    task automatic mdl_reset();
        m_active = 1'b0; m_halt = 1'b0; m_ndm = 1'b0;
        for (int i = 0; i < DC; i++) m_data[i] = 32'h0;
        for (int i = 0; i < PB; i++) m_pb[i] = 32'h0;
    endtask

    function automatic bit mdl_mapped(input logic [31:0] a);
        int w;
        if (a[31:7] != 25'd0) return 1'b0;
        w = int'(a[6:0]);
        if (w >= 4 && w < 4 + DC) return 1'b1;
        if (w == 16 || w == 17 || w == 22) return 1'b1;
        if (PB_EN && w >= 32 && w < 32 + PB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        int w;
        w = int'(a[6:0]);
        if (w >= 4 && w < 4 + DC) return m_data[w - 4];
        if (w >= 32 && w < 32 + PB) return m_pb[w - 32];
        if (w == 16) return (m_halt ? 32'h8000_0000 : 32'h0) | (m_ndm ? 32'h2 : 32'h0) | (m_active ? 32'h1 : 32'h0);
        if (w == 17) return (running ? 32'hC00 : 32'h0) | (halted ? 32'h300 : 32'h0) | 32'h80 | 32'h2;
        if (w == 22) return (PB_EN ? 32'(PB) * 32'h0100_0000 : 32'h0) + 32'(DC);
        return 32'h0;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, output logic rs);
        int w;
        rs = 1'b0;
        w = int'(a[6:0]);
        if (w == 16) begin
            if (!m_active) begin
                m_active = d[0];
            end else if (!d[0]) begin
                mdl_reset();
            end else begin
                m_halt = d[31]; m_ndm = d[1]; rs = d[30];
            end
        end else if (w >= 4 && w < 4 + DC) begin
            if (m_active) m_data[w - 4] = d;
        end else if (w >= 32 && w < 32 + PB) begin
            if (m_active) m_pb[w - 32] = d;
        end
    endtask

    // One Wishbone transaction held for 'hold' extra cycles (data_i changing),
    // checking termination, data, resumereq pulse width and the return to idle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int hold, input logic e_ack, input logic e_err,
                        input logic [31:0] e_rd, input logic e_rs);
        @(negedge clk);
        addr = a; we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("ack", ack, e_ack);
        chk("err", err, e_err);
        chk("data", rdata, e_rd);
        chk("resume", resumereq, e_rs);
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            if (k == hold) begin
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end else begin
                wdata = $urandom;
            end
            @(posedge clk); #1;
            if (k == 0) chk("resume_end", resumereq, 1'b0);
            if (k < hold) begin
                chk("held_ack", ack, e_ack);
                chk("held_err", err, e_err);
                chk("held_data", rdata, e_rd);
            end else begin
                chk("idle_ack", ack, 1'b0);
                chk("idle_err", err, 1'b0);
                chk("idle_data", rdata, 32'h0);
            end
        end
    endtask

    task automatic chk_ctl(input logic e_act, input logic e_ndm, input logic e_halt);
        chk("dmactive", dmactive, e_act);
        chk("ndmreset", ndmreset, e_ndm);
        chk("haltreq", haltreq, e_halt);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_rd;
        logic        e_act;
        logic        e_ndm;
        logic        e_halt;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [31:0] ra, rd, er;
        logic        rw, mp, rs;
        int          sel;

        rst = 1'b1; addr = 32'h0; we = 1'b0; wdata = 32'h0; cyc = 1'b0; stb = 1'b0;
        halted = 1'b0; running = 1'b0;
        mdl_reset();

        // addr, we, wdata, ack, err, rdata, dmactive, ndmreset, haltreq
        vt.push_back('{32'h10, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h16, 1'b0, 32'h0, 1'b1, 1'b0, PB_EN ? 32'h0400_0002 : 32'h0000_0002, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h20, 1'b1, 32'h55, PB_EN, !PB_EN, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h3F, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h8000_0010, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h04, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h04, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h05, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h05, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h06, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h11, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b1, 32'h8000_0003, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1});
        vt.push_back('{32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0003, 1'b1, 1'b1, 1'b1});
        vt.push_back('{32'h10, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h04, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b1, 32'h8000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h04, 1'b1, 32'h0000_AAAA, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h04, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b1, 32'h8000_0003, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h20, 1'b0, 32'h0, PB_EN, !PB_EN, 32'h0, 1'b1, 1'b0, 1'b0});

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        cur_tag = "reset";
        chk("ack", ack, 1'b0);
        chk("err", err, 1'b0);
        chk("data", rdata, 32'h0);
        chk("resume", resumereq, 1'b0);
        chk_ctl(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < vt.size(); i++) begin
            cur_tag = $sformatf("vec%0d", i);
            xfer(vt[i].addr, vt[i].we, vt[i].wdata, 0, vt[i].e_ack, vt[i].e_err, vt[i].e_rd, 1'b0);
            chk_ctl(vt[i].e_act, vt[i].e_ndm, vt[i].e_halt);
        end

        // ---- haltreq then resumereq pulse ----
        cur_tag = "resume";
        xfer(32'h10, 1'b1, 32'h8000_0001, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_ctl(1'b1, 1'b0, 1'b1);
        xfer(32'h10, 1'b1, 32'h4000_0001, 0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk_ctl(1'b1, 1'b0, 1'b0);
        xfer(32'h10, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0000_0001, 1'b0);

        // ---- held ACK write must commit once ----
        cur_tag = "held_wr";
        xfer(32'h04, 1'b1, 32'hDEAD_BEEF, 5, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer(32'h04, 1'b0, 32'h0, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        xfer(32'h3F, 1'b0, 32'h0, 2, 1'b0, 1'b1, 32'h0, 1'b0);
        xfer(32'h10, 1'b1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer(32'h04, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);

        // ---- dmstatus ----
        cur_tag = "dmstatus";
        halted = 1'b1; running = 1'b0;
        xfer(32'h11, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0000_0382, 1'b0);
        halted = 1'b0; running = 1'b1;
        xfer(32'h11, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0000_0C82, 1'b0);

        // ---- reset during held ACK ----
        cur_tag = "rst_ack";
        xfer(32'h10, 1'b1, 32'h0000_0001, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer(32'h10, 1'b1, 32'h8000_0003, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer(32'h05, 1'b1, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        addr = 32'h04; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("ack_pre", ack, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ack", ack, 1'b0);
        chk("err", err, 1'b0);
        chk("data", rdata, 32'h0);
        chk_ctl(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        // write presented together with reset must be dropped
        cur_tag = "rst_drop";
        @(negedge clk);
        rst = 1'b1; addr = 32'h10; we = 1'b1; wdata = 32'h0000_0001; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack", ack, 1'b0);
        chk_ctl(1'b0, 1'b0, 1'b0);
        mdl_reset();
        xfer(32'h05, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer(32'h10, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        xfer(32'h20, 1'b1, 32'h1, 0, PB_EN, !PB_EN, 32'h0, 1'b0);
        xfer(32'h16, 1'b0, 32'h0, 0, 1'b1, 1'b0, PB_EN ? 32'h0400_0002 : 32'h0000_0002, 1'b0);

        // ---- randomized phase against the model ----
        for (int i = 0; i < 250; i++) begin
            cur_tag = $sformatf("rnd%0d", i);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: ra = 32'h04 + 32'($urandom_range(0, DC));
                3, 4:    ra = 32'h10;
                5:       ra = 32'h11;
                6:       ra = 32'h16;
                7:       ra = 32'h20 + 32'($urandom_range(0, PB));
                8:       ra = 32'($urandom_range(0, 63));
                default: begin
                    ra = $urandom;
                    ra[31] = 1'b1;
                end
            endcase
            rw = 1'($urandom_range(0, 1));
            rd = $urandom;
            if (ra == 32'h10 && rw) rd[0] = ($urandom_range(0, 7) != 0);
            halted  = 1'($urandom_range(0, 1));
            running = 1'($urandom_range(0, 1));
            mp = mdl_mapped(ra);
            er = (mp && !rw) ? mdl_read(ra) : 32'h0;
            rs = 1'b0;
            if (mp && rw) mdl_write(ra, rd, rs);
            xfer(ra, rw, rd, $urandom_range(0, 2), mp, !mp, er, rs);
            chk_ctl(m_active, m_ndm, m_halt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
